// File: rtl/sys_reset_gen.sv
// System reset generator: merges power-on reset, core SYSRESETREQ, lockup
// reset and watchdog reset requests into one stretched, registered HRESET for
// the core/AHB domain, and keeps a sticky, write-1-to-clear record of the
// reset cause in RSTINFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no reset in progress, HRESET low
// HOLD     | HRESET high, hold counter running down to zero
// WAIT_REL | hold time expired but a request is still asserted; HRESET stays
//          | high until the first edge that sees no request
//
// HOLD_CYCLES is legal from 2 to 2**CNT_W; the counter is loaded with
// HOLD_CYCLES-1 so a single-cycle request gives exactly HOLD_CYCLES cycles
// of HRESET.

module sys_reset_gen #(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic       FCLK,
  input  logic       PORESET,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUPRESET,
  input  logic       WDOGRESREQ,
  input  logic [3:0] RSTINFO_CLR,
  output logic       HRESET,
  output logic       HRESETn,
  output logic       RST_BUSY,
  output logic [3:0] RSTINFO
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hreset_nxt;
  logic [3:0]       rstinfo_nxt;
  logic [3:0]       rstinfo_set;
  logic             req_any;

  // All request sources live in the FCLK domain, so they are used unsynchronised.
  assign req_any = SYSRESETREQ | LOCKUPRESET | WDOGRESREQ;

  // Cause bits: bit0 (por) is only ever set by the PORESET branch below.
  assign rstinfo_set = {WDOGRESREQ, LOCKUPRESET, SYSRESETREQ, 1'b0};

  // Next-state, hold counter and HRESET decode; requests during HOLD do not reload.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hreset_nxt = HRESET;
    case (state)
      IDLE: begin
        hreset_nxt = 1'b0;
        if (req_any) begin
          state_nxt  = HOLD;
          cnt_nxt    = CNT_LOAD;
          hreset_nxt = 1'b1;
        end
      end
      HOLD: begin
        hreset_nxt = 1'b1;
        if (cnt == '0) begin
          if (req_any) begin
            state_nxt = WAIT_REL;
          end else begin
            state_nxt  = IDLE;
            hreset_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      WAIT_REL: begin
        hreset_nxt = 1'b1;
        if (!req_any) begin
          state_nxt  = IDLE;
          hreset_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        hreset_nxt = 1'b0;
      end
    endcase
  end

  // Sticky cause register: a set in the same cycle beats a clear.
  always_comb begin
    rstinfo_nxt = rstinfo_set | (RSTINFO & ~RSTINFO_CLR);
  end

  // State, counter, HRESET and RSTINFO registers; PORESET restarts a full hold.
  always_ff @(posedge FCLK) begin
    if (PORESET) begin
      state   <= HOLD;
      cnt     <= CNT_LOAD;
      HRESET  <= 1'b1;
      RSTINFO <= 4'b0001;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      HRESET  <= hreset_nxt;
      RSTINFO <= rstinfo_nxt;
    end
  end

  assign HRESETn  = ~HRESET;
  assign RST_BUSY = (state != IDLE);

endmodule

// File: tb/tb_sys_reset_gen.sv
// Directed bench for sys_reset_gen: reset release, pulse and held requests,
// RSTINFO set/clear priority, hold boundaries and PORESET during HOLD.

module tb_sys_reset_gen;

  logic       FCLK;
  logic       PORESET;
  logic       SYSRESETREQ;
  logic       LOCKUPRESET;
  logic       WDOGRESREQ;
  logic [3:0] RSTINFO_CLR;
  logic       HRESET;
  logic       HRESETn;
  logic       RST_BUSY;
  logic [3:0] RSTINFO;

  int n_checks = 0;
  int n_pass   = 0;

  sys_reset_gen #(
    .HOLD_CYCLES (16),
    .CNT_W       (8)
  ) dut (
    .FCLK        (FCLK),
    .PORESET     (PORESET),
    .SYSRESETREQ (SYSRESETREQ),
    .LOCKUPRESET (LOCKUPRESET),
    .WDOGRESREQ  (WDOGRESREQ),
    .RSTINFO_CLR (RSTINFO_CLR),
    .HRESET      (HRESET),
    .HRESETn     (HRESETn),
    .RST_BUSY    (RST_BUSY),
    .RSTINFO     (RSTINFO)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  // Counts consecutive samples with HRESET=1 starting at the current one,
  // checking RST_BUSY/HRESETn track HRESET throughout; bounded at 200 cycles.
  task automatic pulse_len(input string tag, input int exp_len);
    int  n;
    logic side_ok;
    n = 0;
    side_ok = 1'b1;
    while (HRESET === 1'b1 && n < 200) begin
      if (RST_BUSY !== 1'b1 || HRESETn !== 1'b0) side_ok = 1'b0;
      n++;
      tick();
    end
    check({tag, "_len"}, n, exp_len);
    check({tag, "_busy_track"}, {31'd0, side_ok}, 32'd1);
    check({tag, "_idle_busy"}, {31'd0, RST_BUSY}, 32'd0);
    check({tag, "_idle_hresetn"}, {31'd0, HRESETn}, 32'd1);
  endtask

  task automatic clear_all();
    RSTINFO_CLR = 4'b1111;
    tick();
    RSTINFO_CLR = 4'b0000;
  endtask

  initial begin
    PORESET     = 1'b1;
    SYSRESETREQ = 1'b0;
    LOCKUPRESET = 1'b0;
    WDOGRESREQ  = 1'b0;
    RSTINFO_CLR = 4'b0000;

    // 1: power-on reset and release
    repeat (3) tick();
    check("por_hreset",   {31'd0, HRESET},   32'd1);
    check("por_hresetn",  {31'd0, HRESETn},  32'd0);
    check("por_busy",     {31'd0, RST_BUSY}, 32'd1);
    check("por_rstinfo",  {28'd0, RSTINFO},  32'h1);
    PORESET = 1'b0;
    pulse_len("por_release", 16);
    check("por_rstinfo_after", {28'd0, RSTINFO}, 32'h1);

    // 2: clear then single-cycle SYSRESETREQ
    clear_all();
    check("clr_all_rstinfo", {28'd0, RSTINFO}, 32'h0);
    check("idle_hreset",     {31'd0, HRESET},  32'd0);
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    check("sysreq_latency", {31'd0, HRESET}, 32'd1);
    pulse_len("sysreq_pulse", 16);
    check("sysreq_rstinfo", {28'd0, RSTINFO}, 32'h2);

    // 3: LOCKUPRESET held for 40 cycles
    clear_all();
    LOCKUPRESET = 1'b1;
    repeat (16) tick();
    check("lockup_hold_end", {31'd0, HRESET}, 32'd1);
    tick();
    check("lockup_wait_rel",      {31'd0, HRESET},   32'd1);
    check("lockup_wait_rel_busy", {31'd0, RST_BUSY}, 32'd1);
    repeat (23) tick();
    LOCKUPRESET = 1'b0;
    check("lockup_before_drop_edge", {31'd0, HRESET}, 32'd1);
    tick();
    check("lockup_release",      {31'd0, HRESET},   32'd0);
    check("lockup_release_busy", {31'd0, RST_BUSY}, 32'd0);
    check("lockup_rstinfo",      {28'd0, RSTINFO},  32'h4);

    // 4: WDOGRESREQ and SYSRESETREQ together
    clear_all();
    check("clr_lockup_rstinfo", {28'd0, RSTINFO}, 32'h0);
    WDOGRESREQ  = 1'b1;
    SYSRESETREQ = 1'b1;
    tick();
    WDOGRESREQ  = 1'b0;
    SYSRESETREQ = 1'b0;
    pulse_len("dual_req", 16);
    check("dual_rstinfo", {28'd0, RSTINFO}, 32'hA);

    // 5: set beats clear, clear alone drops the bit
    SYSRESETREQ = 1'b1;
    RSTINFO_CLR = 4'b0010;
    tick();
    SYSRESETREQ = 1'b0;
    RSTINFO_CLR = 4'b0000;
    check("set_wins_rstinfo", {28'd0, RSTINFO}, 32'hA);
    pulse_len("set_wins_pulse", 16);
    RSTINFO_CLR = 4'b0010;
    tick();
    RSTINFO_CLR = 4'b0000;
    check("clr_bit1_rstinfo", {28'd0, RSTINFO}, 32'h8);
    RSTINFO_CLR = 4'b1000;
    tick();
    RSTINFO_CLR = 4'b0000;
    check("clr_bit3_rstinfo", {28'd0, RSTINFO}, 32'h0);

    // 7: a second request during HOLD does not reload the counter
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    repeat (4) tick();
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    pulse_len("no_reload", 11);

    // 8: request on the cnt==0 edge goes through WAIT_REL for one extra cycle
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    repeat (15) tick();
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    check("cnt0_req_hreset", {31'd0, HRESET},   32'd1);
    check("cnt0_req_busy",   {31'd0, RST_BUSY}, 32'd1);
    tick();
    check("cnt0_req_release", {31'd0, HRESET}, 32'd0);

    // 6: PORESET during HOLD at cnt=5 reloads the full hold
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    repeat (10) tick();
    PORESET = 1'b1;
    tick();
    PORESET = 1'b0;
    check("por_mid_rstinfo", {28'd0, RSTINFO}, 32'h1);
    pulse_len("por_mid_hold", 16);
    check("por_mid_rstinfo_after", {28'd0, RSTINFO}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
